// File: rtl/dot_acc16.sv
// dot_acc16 -- saturating dot-product accumulator for one frame of signed
// 16-bit product terms (output of an 8x8 signed multiplier stage).
//
// A frame opens with the first accepted term and closes with the accepted
// term that carries p_last. The frame sum, the number of terms and a sticky
// saturation flag are then held on r/r_cnt/r_ovf with r_valid high until
// downstream takes them with r_ready. The block accepts nothing while a
// result is held, and it accepts nothing on the handshake cycle either.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous, active-high reset
//   p        in   [15:0] signed product term
//   p_valid  in   p/p_last valid this cycle
//   p_last   in   p is the final term of the frame (only with p_valid)
//   p_ready  out  a term is accepted this cycle if p_valid is high
//   r        out  [ACC_W-1:0] signed saturated frame sum
//   r_cnt    out  [7:0] accepted terms in the frame, saturating at 255
//   r_ovf    out  the frame clamped at least once
//   r_valid  out  r/r_cnt/r_ovf hold a completed frame
//   r_ready  in   downstream takes the result this cycle
module dot_acc16 #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      p,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  output logic [ACC_W-1:0] r,
  output logic [7:0]       r_cnt,
  output logic             r_ovf,
  output logic             r_valid,
  input  logic             r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Clamp limits expressed one bit wider than the accumulator so the true
  // sum of a full-range accumulator and a term can be compared exactly.
  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [7:0]       cnt_r;
  logic             ovf_r;
  logic             valid_r;

  logic             accept_s;
  logic [ACC_W:0]   sum_s;      // {clamped, clamped value}
  logic [ACC_W-1:0] first_s;
  logic [7:0]       cnt_inc_s;

  // Sign-extend a 16-bit term to accumulator width.
  function automatic logic [ACC_W-1:0] sext_term(input logic [15:0] t);
    return {{(ACC_W-16){t[15]}}, t};
  endfunction

  // Add a term to the accumulator and clamp into the signed ACC_W range.
  // The MSB of the result reports whether the clamp was applied.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [15:0]      t);
    logic signed [ACC_W:0] s;
    logic [ACC_W:0]        res;
    s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W-15){t[15]}}, t});
    if (s > SUM_MAX) begin
      res = {1'b1, SUM_MAX[ACC_W-1:0]};
    end else if (s < SUM_MIN) begin
      res = {1'b1, SUM_MIN[ACC_W-1:0]};
    end else begin
      res = {1'b0, s[ACC_W-1:0]};
    end
    return res;
  endfunction

  // Term counter increment that sticks at 255.
  function automatic logic [7:0] cnt_sat_inc(input logic [7:0] c);
    logic [7:0] res;
    if (c == 8'd255) begin
      res = c;
    end else begin
      res = c + 8'd1;
    end
    return res;
  endfunction

  // p_ready follows the state register but is forced low during reset,
  // because reset parks the state in IDLE where p_ready would otherwise be 1.
  assign p_ready   = ~rst & (state_r != HOLD);
  assign accept_s  = p_valid & p_ready;
  assign sum_s     = sat_add(acc_r, p);
  assign first_s   = sext_term(p);
  assign cnt_inc_s = cnt_sat_inc(cnt_r);

  assign r       = acc_r;
  assign r_cnt   = cnt_r;
  assign r_ovf   = ovf_r;
  assign r_valid = valid_r;

  // Frame FSM with accumulator, counter, overflow flag and r_valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= 8'd0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // First term of a frame cannot overflow since ACC_W > 16.
            acc_r <= first_s;
            cnt_r <= 8'd1;
            ovf_r <= 1'b0;
            if (p_last) begin
              state_r <= HOLD;
              valid_r <= 1'b1;
            end else begin
              state_r <= ACC;
            end
          end
        end
        ACC: begin
          if (accept_s) begin
            acc_r <= sum_s[ACC_W-1:0];
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_r | sum_s[ACC_W];
            if (p_last) begin
              state_r <= HOLD;
              valid_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Result registers are left untouched so they stay stable while held.
          if (r_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_acc16.sv
module tb_dot_acc16;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] p = 16'd0;
  logic        p_valid = 1'b0;
  logic        p_last = 1'b0;
  logic        r_ready = 1'b0;

  // Instance a: default ACC_W=24; instance b: ACC_W=17. Both share inputs.
  logic               p_ready_a, p_ready_b;
  logic signed [23:0] r_a;
  logic signed [16:0] r_b;
  logic [7:0]         cnt_a, cnt_b;
  logic               ovf_a, ovf_b, rv_a, rv_b;

  int checks = 0;
  int failures = 0;

  // Reference model state: terms of the open frame and a held-result flag.
  longint frame[$];
  bit     holding = 1'b0;
  longint e_r24, e_r17;
  bit     e_o24, e_o17;
  int     e_cnt;

  dot_acc16 #(.ACC_W(24)) dut_a (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_last(p_last),
    .p_ready(p_ready_a), .r(r_a), .r_cnt(cnt_a), .r_ovf(ovf_a),
    .r_valid(rv_a), .r_ready(r_ready)
  );

  dot_acc16 #(.ACC_W(17)) dut_b (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_last(p_last),
    .p_ready(p_ready_b), .r(r_b), .r_cnt(cnt_b), .r_ovf(ovf_b),
    .r_valid(rv_b), .r_ready(r_ready)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic v, input logic l,
                       input logic rr);
    p = d; p_valid = v; p_last = l; r_ready = rr;
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk({tag, ".p_ready_a"}, p_ready_a, exp);
    chk({tag, ".p_ready_b"}, p_ready_b, exp);
  endtask

  task automatic chk_rv(input string tag, input logic exp);
    chk({tag, ".r_valid_a"}, rv_a, exp);
    chk({tag, ".r_valid_b"}, rv_b, exp);
  endtask

  task automatic chk_res(input string tag, input longint x24, input bit o24,
                         input longint x17, input bit o17, input int c);
    chk({tag, ".r_a"}, r_a, x24);
    chk({tag, ".ovf_a"}, ovf_a, o24);
    chk({tag, ".cnt_a"}, cnt_a, c);
    chk({tag, ".r_b"}, r_b, x17);
    chk({tag, ".ovf_b"}, ovf_b, o17);
    chk({tag, ".cnt_b"}, cnt_b, c);
  endtask

  // Frame result from the list of terms: running sum clamped to a w-bit
  // signed range after every addition.
  task automatic model_frame(input int w, output longint res, output bit ov);
    longint mx, mn, acc;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    acc = frame[0];
    ov = 1'b0;
    for (int i = 1; i < frame.size(); i++) begin
      acc = acc + frame[i];
      if (acc > mx) begin acc = mx; ov = 1'b1; end
      else if (acc < mn) begin acc = mn; ov = 1'b1; end
    end
    res = acc;
  endtask

  initial begin
    // Reset with clock stopped
    #2;
    chk_rv("rst0", 1'b0);
    chk_ready("rst0", 1'b0);
    chk_res("rst0", 0, 1'b0, 0, 1'b0, 0);
    rst = 1'b0;
    #1;
    chk_ready("rel0", 1'b1);
    clk_en = 1'b1;
    tick();

    // 100, -50, 7 on consecutive cycles
    drive(16'd100, 1'b1, 1'b0, 1'b1);
    tick();
    chk_rv("f1.t1", 1'b0);
    drive(-16'sd50, 1'b1, 1'b0, 1'b1);
    tick();
    chk_rv("f1.t2", 1'b0);
    drive(16'd7, 1'b1, 1'b1, 1'b1);
    tick();
    chk_rv("f1.hold", 1'b1);
    chk_ready("f1.hold", 1'b0);
    chk_res("f1", 57, 1'b0, 57, 1'b0, 3);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_rv("f1.after", 1'b0);
    chk_ready("f1.after", 1'b1);

    // Single most-negative term
    drive(16'h8000, 1'b1, 1'b1, 1'b1);
    tick();
    chk_rv("f2", 1'b1);
    chk_res("f2", -32768, 1'b0, -32768, 1'b0, 1);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Saturation in the 17-bit instance, then a clean frame
    drive(16'd32767, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    drive(16'd32767, 1'b1, 1'b1, 1'b1);
    tick();
    chk_rv("f3", 1'b1);
    chk_res("f3", 98301, 1'b0, 65535, 1'b1, 3);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'd5, 1'b1, 1'b1, 1'b1);
    tick();
    chk_res("f4", 5, 1'b0, 5, 1'b0, 1);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Back-pressure: result held 5 cycles with a pending term
    drive(16'd10, 1'b1, 1'b1, 1'b0);
    tick();
    drive(16'd20, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_rv("bp.hold", 1'b1);
      chk_ready("bp.hold", 1'b0);
      chk_res("bp.hold", 10, 1'b0, 10, 1'b0, 1);
    end
    r_ready = 1'b1;
    tick();
    chk_rv("bp.idle", 1'b0);
    chk_ready("bp.idle", 1'b1);
    tick();
    chk_rv("bp.next", 1'b1);
    chk_res("bp.next", 20, 1'b0, 20, 1'b0, 1);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Held frame discarded by reset with clock stopped
    drive(16'd9, 1'b1, 1'b1, 1'b0);
    tick();
    chk_rv("hr.hold", 1'b1);
    drive(16'd0, 1'b0, 1'b0, 1'b0);
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    chk_rv("hr.rst", 1'b0);
    chk_ready("hr.rst", 1'b0);
    chk_res("hr.rst", 0, 1'b0, 0, 1'b0, 0);
    rst = 1'b0;
    #1;
    chk_ready("hr.rel", 1'b1);
    clk_en = 1'b1;
    tick();
    chk_rv("hr.after", 1'b0);

    // Reset after 2 of 4 terms, then a fresh frame 3, 4
    drive(16'd1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(16'd2, 1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    #2;
    chk_rv("mr.rst", 1'b0);
    chk_res("mr.rst", 0, 1'b0, 0, 1'b0, 0);
    rst = 1'b0;
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_rv("mr.idle", 1'b0);
    drive(16'd3, 1'b1, 1'b0, 1'b1);
    tick();
    chk_rv("mr.t3", 1'b0);
    drive(16'd4, 1'b1, 1'b1, 1'b1);
    tick();
    chk_rv("mr.res", 1'b1);
    chk_res("mr.res", 7, 1'b0, 7, 1'b0, 2);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Counter saturation: 300 terms of 1
    for (int i = 0; i < 300; i++) begin
      drive(16'd1, 1'b1, (i == 299), 1'b0);
      tick();
    end
    chk_rv("long", 1'b1);
    chk_res("long", 300, 1'b0, 300, 1'b0, 255);
    drive(16'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_rv("long.after", 1'b0);

    // Randomized traffic against the frame-level model
    frame.delete();
    holding = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      case ($urandom_range(0, 3))
        0: p = 16'h7fff;
        1: p = 16'h8000;
        default: p = 16'($urandom);
      endcase
      p_valid = ($urandom_range(0, 3) != 0);
      p_last  = ($urandom_range(0, 5) == 0);
      r_ready = ($urandom_range(0, 2) != 0);
      chk_ready("rnd", !holding);
      if (holding) begin
        if (r_ready) holding = 1'b0;
      end else if (p_valid) begin
        frame.push_back(longint'($signed(p)));
        if (p_last) begin
          model_frame(24, e_r24, e_o24);
          model_frame(17, e_r17, e_o17);
          e_cnt = (frame.size() > 255) ? 255 : frame.size();
          frame.delete();
          holding = 1'b1;
        end
      end
      tick();
      chk_rv("rnd", holding);
      if (holding) chk_res("rnd", e_r24, e_o24, e_r17, e_o17, e_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
